// File: rtl/mem_port_arbiter.sv
// Single-bus arbiter between the instruction fetch and data ports of the pipeline.
// One transaction in flight: IDLE -> REQ -> WAIT -> DONE, with fetch anti-starvation and timeout.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  output logic                if_stall,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ack,
  output logic                dm_stall,
  output logic                bus_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  state_t     state_reg;
  logic       owner_dm_reg;
  logic [7:0] starve_cnt_reg;
  logic [7:0] to_cnt_reg;
  logic       fetch_win;
  logic       data_win;

  // Data normally has priority; fetch wins once it has been passed over STARVE_LIMIT times.
  assign fetch_win = if_req && (!dm_req || (starve_cnt_reg == STARVE_MAX));
  assign data_win  = dm_req && !fetch_win;

  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dm_req & ~dm_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      owner_dm_reg   <= 1'b0;
      starve_cnt_reg <= '0;
      to_cnt_reg     <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_be         <= '0;
      if_rdata       <= '0;
      dm_rdata       <= '0;
      if_ack         <= 1'b0;
      dm_ack         <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      if_ack  <= 1'b0;
      dm_ack  <= 1'b0;
      bus_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (fetch_win || data_win) begin
            owner_dm_reg <= data_win;
            mem_addr     <= fetch_win ? if_addr : dm_addr;
            mem_we       <= fetch_win ? 1'b0 : dm_we;
            mem_wdata    <= fetch_win ? '0 : dm_wdata;
            mem_be       <= fetch_win ? '1 : dm_be;
            mem_req      <= 1'b1;
            to_cnt_reg   <= '0;
            state_reg    <= REQ;
            if (data_win && if_req) begin
              if (starve_cnt_reg != STARVE_MAX)
                starve_cnt_reg <= starve_cnt_reg + 8'd1;
            end else begin
              starve_cnt_reg <= '0;
            end
          end
        end
        REQ: begin
          // Any rvalid seen here is ignored: a response cannot share the grant cycle.
          if (mem_gnt) begin
            mem_req    <= 1'b0;
            to_cnt_reg <= '0;
            state_reg  <= WAIT;
          end else if (to_cnt_reg == TO_LAST) begin
            mem_req   <= 1'b0;
            bus_err   <= 1'b1;
            state_reg <= DONE;
            if (owner_dm_reg) begin
              dm_rdata <= '0;
              dm_ack   <= 1'b1;
            end else begin
              if_rdata <= '0;
              if_ack   <= 1'b1;
            end
          end else begin
            to_cnt_reg <= to_cnt_reg + 8'd1;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state_reg <= DONE;
            if (owner_dm_reg) begin
              dm_rdata <= mem_we ? '0 : mem_rdata;
              dm_ack   <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
          end else if (to_cnt_reg == TO_LAST) begin
            bus_err   <= 1'b1;
            state_reg <= DONE;
            if (owner_dm_reg) begin
              dm_rdata <= '0;
              dm_ack   <= 1'b1;
            end else begin
              if_rdata <= '0;
              if_ack   <= 1'b1;
            end
          end else begin
            to_cnt_reg <= to_cnt_reg + 8'd1;
          end
        end
        DONE: begin
          // No arbitration here so the finishing requester's held req is not re-granted.
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small scripted memory responder plus one task per scenario.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack, if_stall;
  logic          dm_req, dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [3:0]    dm_be;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack, dm_stall, bus_err;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_gnt, mem_rvalid;
  logic [DW-1:0] mem_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  // responder knobs
  int          gnt_dly = 0;
  int          rv_dly = 1;
  logic [31:0] rd_value = '0;
  bit          pending = 0;
  int          req_cycles = 0;
  int          wait_cycles = 0;

  // results of the last wait_ack
  int          lat_v, req_hi_v;
  bit          cmd_stable_v, stall_held_v;
  logic        ack_if_v, ack_dm_v, err_v;
  logic [31:0] first_addr_v, first_wdata_v;
  logic        first_we_v;
  logic [3:0]  first_be_v;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: grant after gnt_dly REQ cycles, respond rv_dly cycles after the grant.
  initial begin
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (pending) begin
        wait_cycles++;
        if (wait_cycles >= rv_dly) begin
          mem_rvalid = 1'b1;
          mem_rdata = rd_value;
          pending = 0;
        end
      end
      if (mem_req && !pending) begin
        if (req_cycles == gnt_dly) begin
          mem_gnt = 1'b1;
          pending = 1;
          wait_cycles = 0;
          req_cycles = 0;
        end else begin
          req_cycles++;
        end
      end else begin
        req_cycles = 0;
      end
    end
  end

  // Steps the clock until an ack appears, recording latency and bus activity.
  task automatic wait_ack(input int max_cyc);
    lat_v = -1; req_hi_v = 0; cmd_stable_v = 1; stall_held_v = 1;
    ack_if_v = 0; ack_dm_v = 0; err_v = 0;
    for (int n = 1; n <= max_cyc; n++) begin
      @(posedge clk); #1;
      if (mem_req) begin
        if (req_hi_v == 0) begin
          first_addr_v = mem_addr; first_we_v = mem_we;
          first_wdata_v = mem_wdata; first_be_v = mem_be;
        end else if (mem_addr !== first_addr_v || mem_we !== first_we_v ||
                     mem_wdata !== first_wdata_v || mem_be !== first_be_v) begin
          cmd_stable_v = 0;
        end
        req_hi_v++;
      end
      if (if_ack || dm_ack) begin
        lat_v = n; ack_if_v = if_ack; ack_dm_v = dm_ack; err_v = bus_err;
        break;
      end
      if ((if_req && !if_stall) || (dm_req && !dm_stall)) stall_held_v = 0;
    end
    $display("[TB] txn ack_if=%0b ack_dm=%0b lat=%0d req_cycles=%0d addr=%h we=%0b err=%0b",
             ack_if_v, ack_dm_v, lat_v, req_hi_v, first_addr_v, first_we_v, err_v);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_req got %0b exp 0", mem_req); end
    tests_run++; if ({if_ack, dm_ack, bus_err} !== 3'b000) begin tests_failed++; $display("FAIL rst_acks got %b exp 000", {if_ack, dm_ack, bus_err}); end
    tests_run++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_rdata got %h/%h exp 0/0", if_rdata, dm_rdata); end
    tests_run++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0) begin tests_failed++; $display("FAIL rst_bus got addr=%h be=%h exp 0", mem_addr, mem_be); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (mem_req !== 1'b0 || if_stall !== 1'b0) begin tests_failed++; $display("FAIL rst_idle got req=%0b stall=%0b exp 0", mem_req, if_stall); end
  endtask

  task automatic test_fetch_read();
    gnt_dly = 0; rv_dly = 1; rd_value = 32'h2408_0005;
    if_addr = 32'h0000_0040; if_req = 1'b1;
    #1;
    tests_run++; if (if_stall !== 1'b1) begin tests_failed++; $display("FAIL fetch_stall_early got %0b exp 1", if_stall); end
    wait_ack(40);
    tests_run++; if (lat_v !== 3) begin tests_failed++; $display("FAIL fetch_latency got %0d exp 3", lat_v); end
    tests_run++; if (req_hi_v !== 1) begin tests_failed++; $display("FAIL fetch_req_cycles got %0d exp 1", req_hi_v); end
    tests_run++; if (first_addr_v !== 32'h40 || first_we_v !== 1'b0 || first_be_v !== 4'hF) begin tests_failed++; $display("FAIL fetch_cmd got addr=%h we=%0b be=%h exp 40/0/f", first_addr_v, first_we_v, first_be_v); end
    tests_run++; if (ack_if_v !== 1'b1 || ack_dm_v !== 1'b0 || err_v !== 1'b0) begin tests_failed++; $display("FAIL fetch_ack got if=%0b dm=%0b err=%0b exp 1/0/0", ack_if_v, ack_dm_v, err_v); end
    tests_run++; if (if_rdata !== 32'h2408_0005) begin tests_failed++; $display("FAIL fetch_rdata got %h exp 24080005", if_rdata); end
    tests_run++; if (stall_held_v !== 1'b1 || if_stall !== 1'b0) begin tests_failed++; $display("FAIL fetch_stall got held=%0b at_ack=%0b exp 1/0", stall_held_v, if_stall); end
    if_req = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (if_ack !== 1'b0 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL fetch_ack_pulse got ack=%0b req=%0b exp 0/0", if_ack, mem_req); end
  endtask

  task automatic test_data_write();
    gnt_dly = 0; rv_dly = 1; rd_value = 32'h1234_5678;
    dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011; dm_req = 1'b1;
    wait_ack(40);
    tests_run++; if (first_addr_v !== 32'h100 || first_we_v !== 1'b1 || first_wdata_v !== 32'hDEAD_BEEF || first_be_v !== 4'b0011) begin tests_failed++; $display("FAIL write_cmd got %h/%0b/%h/%h exp 100/1/deadbeef/3", first_addr_v, first_we_v, first_wdata_v, first_be_v); end
    tests_run++; if (ack_dm_v !== 1'b1 || ack_if_v !== 1'b0 || err_v !== 1'b0 || lat_v !== 3) begin tests_failed++; $display("FAIL write_ack got dm=%0b if=%0b err=%0b lat=%0d exp 1/0/0/3", ack_dm_v, ack_if_v, err_v, lat_v); end
    tests_run++; if (dm_rdata !== 32'h0) begin tests_failed++; $display("FAIL write_rdata got %h exp 0", dm_rdata); end
    dm_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_data_read();
    gnt_dly = 0; rv_dly = 1; rd_value = 32'hCAFE_0001;
    dm_we = 1'b0; dm_addr = 32'h104; dm_req = 1'b1;
    wait_ack(40);
    tests_run++; if (ack_dm_v !== 1'b1 || lat_v !== 3) begin tests_failed++; $display("FAIL read_ack got dm=%0b lat=%0d exp 1/3", ack_dm_v, lat_v); end
    tests_run++; if (dm_rdata !== 32'hCAFE_0001) begin tests_failed++; $display("FAIL read_rdata got %h exp cafe0001", dm_rdata); end
    tests_run++; if (if_rdata !== 32'h2408_0005) begin tests_failed++; $display("FAIL if_rdata_hold got %h exp 24080005", if_rdata); end
    dm_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int exp_dm[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    gnt_dly = 0; rv_dly = 1; rd_value = 32'h55AA_0000;
    if_addr = 32'h80; dm_we = 1'b0; dm_addr = 32'h200;
    if_req = 1'b1; dm_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_ack(40);
      tests_run++; if (ack_dm_v !== exp_dm[k][0] || (ack_if_v ^ ack_dm_v) !== 1'b1) begin tests_failed++; $display("FAIL grant_order_%0d got if=%0b dm=%0b exp dm=%0d", k, ack_if_v, ack_dm_v, exp_dm[k]); end
      tests_run++; if (lat_v !== ((k == 0) ? 3 : 4)) begin tests_failed++; $display("FAIL b2b_interval_%0d got %0d exp %0d", k, lat_v, (k == 0) ? 3 : 4); end
    end
    if_req = 1'b0; dm_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_wait_states();
    gnt_dly = 2; rv_dly = 3; rd_value = 32'h0BAD_F00D;
    dm_we = 1'b0; dm_addr = 32'h300; dm_be = 4'hC; dm_req = 1'b1;
    wait_ack(40);
    tests_run++; if (req_hi_v !== 3 || cmd_stable_v !== 1'b1) begin tests_failed++; $display("FAIL ws_req got cycles=%0d stable=%0b exp 3/1", req_hi_v, cmd_stable_v); end
    tests_run++; if (lat_v !== 7 || ack_dm_v !== 1'b1) begin tests_failed++; $display("FAIL ws_latency got %0d dm=%0b exp 7/1", lat_v, ack_dm_v); end
    tests_run++; if (stall_held_v !== 1'b1) begin tests_failed++; $display("FAIL ws_stall got held=%0b exp 1", stall_held_v); end
    tests_run++; if (dm_rdata !== 32'h0BAD_F00D || err_v !== 1'b0) begin tests_failed++; $display("FAIL ws_rdata got %h err=%0b exp 0badf00d/0", dm_rdata, err_v); end
    dm_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    gnt_dly = 1000; rv_dly = 1; rd_value = 32'hFFFF_FFFF;
    if_addr = 32'h84; if_req = 1'b1;
    wait_ack(40);
    tests_run++; if (req_hi_v !== 8) begin tests_failed++; $display("FAIL to_req_cycles got %0d exp 8", req_hi_v); end
    tests_run++; if (lat_v !== 9 || ack_if_v !== 1'b1 || ack_dm_v !== 1'b0) begin tests_failed++; $display("FAIL to_ack got lat=%0d if=%0b dm=%0b exp 9/1/0", lat_v, ack_if_v, ack_dm_v); end
    tests_run++; if (err_v !== 1'b1 || if_rdata !== 32'h0 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL to_err got err=%0b rdata=%h req=%0b exp 1/0/0", err_v, if_rdata, mem_req); end
    if_req = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (bus_err !== 1'b0 || if_ack !== 1'b0) begin tests_failed++; $display("FAIL to_pulse got err=%0b ack=%0b exp 0/0", bus_err, if_ack); end
  endtask

  task automatic test_reset_mid();
    bit saw_rv;
    bit any_ack;
    // reset while the command is on the bus
    gnt_dly = 1000; if_addr = 32'h300; if_req = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL rreq_pre got %0b exp 1", mem_req); end
    #3 rst = 1'b0;
    #1;
    tests_run++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin tests_failed++; $display("FAIL rreq_async got req=%0b addr=%h exp 0/0", mem_req, mem_addr); end
    if_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    // reset while waiting for the response
    gnt_dly = 0; rv_dly = 6; rd_value = 32'h7777_7777;
    if_addr = 32'h40; if_req = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    #3 rst = 1'b0;
    #1;
    tests_run++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || if_ack !== 1'b0 || dm_ack !== 1'b0) begin tests_failed++; $display("FAIL rwait_async got req=%0b addr=%h acks=%0b%0b exp 0/0/00", mem_req, mem_addr, if_ack, dm_ack); end
    if_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    saw_rv = 0; any_ack = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (mem_rvalid) saw_rv = 1;
      if (if_ack || dm_ack || mem_req) any_ack = 1;
    end
    tests_run++; if (saw_rv !== 1'b1 || any_ack !== 1'b0) begin tests_failed++; $display("FAIL stray_rvalid got seen=%0b activity=%0b exp 1/0", saw_rv, any_ack); end
    gnt_dly = 0; rv_dly = 1; rd_value = 32'h1111_2222;
    if_addr = 32'h44; if_req = 1'b1;
    wait_ack(40);
    tests_run++; if (lat_v !== 3 || ack_if_v !== 1'b1 || if_rdata !== 32'h1111_2222 || err_v !== 1'b0) begin tests_failed++; $display("FAIL post_reset_fetch got lat=%0d ack=%0b rdata=%h err=%0b exp 3/1/11112222/0", lat_v, ack_if_v, if_rdata, err_v); end
    if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    test_reset();
    test_fetch_read();
    test_data_write();
    test_data_read();
    test_back_to_back();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
